// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared types and helpers for the AHB-Lite to APB3 bridge:
//   htrans_t       - AHB transfer type encoding
//   hresp_t        - AHB response encoding (HRESP_OKAY / HRESP_ERROR)
//   bridge_state_t - bridge FSM state encoding
//   slv_dec_t      - decode result (hit flag + slave index)
//   slv_decode()   - address to slave-window decode
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        BS_IDLE   = 3'd0,
        BS_WWAIT  = 3'd1,
        BS_SETUP  = 3'd2,
        BS_ACCESS = 3'd3,
        BS_ERR1   = 3'd4,
        BS_ERR2   = 3'd5
    } bridge_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } slv_dec_t;

    // Slave i owns [base + i*2^win_log2, base + (i+1)*2^win_log2).
    // Addresses are widened to 64 bits so the subtraction below the base
    // wraps harmlessly and is rejected by the addr >= base term.
    function automatic slv_dec_t slv_decode(input logic [63:0] addr,
                                            input logic [63:0] base,
                                            input int unsigned win_log2,
                                            input int unsigned nslv);
        slv_dec_t    res;
        logic [63:0] slot;
        slot    = (addr - base) >> win_log2;
        res.hit = (addr >= base) && (slot < 64'(nslv));
        res.idx = slot[3:0];
        return res;
    endfunction

endpackage

// File: rtl/ahb_apb_decode.sv
// ---------------------------------------------------------------------------
// ahb_apb_decode
// Combinational address decode into a one-hot APB slave select.
// Ports:
//   addr  in  ADDR_W  AHB address
//   sel   out NSLV    one-hot select (all zero when unmapped)
//   hit   out 1       address falls inside one of the NSLV windows
// ---------------------------------------------------------------------------
module ahb_apb_decode #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          NSLV         = 4,
    parameter logic [ADDR_W-1:0]    SLV_BASE     = 32'h8000_0000,
    parameter int unsigned          SLV_WIN_LOG2 = 26
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSLV-1:0]   sel,
    output logic              hit
);
    import ahb_apb_pkg::*;

    slv_dec_t dec_s;

    // Window decode and one-hot expansion
    always_comb begin
        dec_s = slv_decode(64'(addr), 64'(SLV_BASE), SLV_WIN_LOG2, NSLV);
        hit   = dec_s.hit;
        if (dec_s.hit) begin
            sel = NSLV'(1'b1) << dec_s.idx;
        end else begin
            sel = {NSLV{1'b0}};
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_mc
// AHB-Lite slave to APB3 master bridge with N-way decode, Pready wait
// states, Pslverr to two-cycle AHB ERROR mapping, unmapped-address and
// illegal-size errors, and back-to-back transfers.
// Optional feature: define AHB_APB_TIMEOUT_EN to enable a Pready watchdog
// that aborts an ACCESS phase stalled for TIMEOUT cycles with an ERROR.
// Ports:
//   Hclk, Hrestn                 clock, async active-low reset
//   Haddr/Htrans/Hwrite/Hsize    AHB address phase
//   Hwdata                       AHB write data (data phase)
//   Hreadyin                     bus HREADY
//   Hreadyout/Hresp/Hrdata       AHB slave response
//   Pselx/Penable/Pwrite/Paddr/Pwdata   APB master outputs (registered)
//   Prdata/Pready/Pslverr        APB slave response
// ---------------------------------------------------------------------------
module ahb_apb_bridge_mc #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       NSLV         = 4,
    parameter logic [ADDR_W-1:0] SLV_BASE     = 32'h8000_0000,
    parameter int unsigned       SLV_WIN_LOG2 = 26,
    parameter int unsigned       TIMEOUT      = 16
) (
    input  logic              Hclk,
    input  logic              Hrestn,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [1:0]        Htrans,
    input  logic              Hwrite,
    input  logic [2:0]        Hsize,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Hreadyin,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr
);
    import ahb_apb_pkg::*;

    localparam logic [2:0] S_IDLE   = BS_IDLE;
    localparam logic [2:0] S_WWAIT  = BS_WWAIT;
    localparam logic [2:0] S_SETUP  = BS_SETUP;
    localparam logic [2:0] S_ACCESS = BS_ACCESS;
    localparam logic [2:0] S_ERR1   = BS_ERR1;
    localparam logic [2:0] S_ERR2   = BS_ERR2;

    // Largest legal Hsize: log2 of the data-bus byte width.
    localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [2:0]        new_state_s;
    logic [NSLV-1:0]   sel_s;
    logic              hit_s;
    logic              hready_s;
    logic              accept_s;
    logic              bad_s;
    logic              tmo_s;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic [NSLV-1:0]   sel_r;
    logic [ADDR_W-1:0] ld_addr_s;
    logic              ld_write_s;
    logic [NSLV-1:0]   ld_sel_s;
    logic [NSLV-1:0]   psel_r;
    logic              penable_r;
    logic [ADDR_W-1:0] paddr_r;
    logic              pwrite_r;
    logic [DATA_W-1:0] pwdata_r;
    logic [1:0]        hresp_r;

    ahb_apb_decode #(
        .ADDR_W      (ADDR_W),
        .NSLV        (NSLV),
        .SLV_BASE    (SLV_BASE),
        .SLV_WIN_LOG2(SLV_WIN_LOG2)
    ) u_decode (
        .addr(Haddr),
        .sel (sel_s),
        .hit (hit_s)
    );

    // Bridge ready: the only combinational AHB output besides read data
    always_comb begin
        case (state_r)
            S_IDLE, S_ERR2: hready_s = 1'b1;
            S_ACCESS:       hready_s = Pready & ~Pslverr;
            default:        hready_s = 1'b0;
        endcase
    end

    assign accept_s = hready_s & Hreadyin &
                      ((Htrans == TR_NONSEQ) | (Htrans == TR_SEQ));
    assign bad_s    = ~hit_s | (Hsize > MAX_SIZE);

    // Destination for a freshly accepted transfer
    always_comb begin
        if (bad_s) begin
            new_state_s = S_ERR1;
        end else if (Hwrite) begin
            new_state_s = S_WWAIT;
        end else begin
            new_state_s = S_SETUP;
        end
    end

    // A read accepted in the same cycle that enters SETUP has not been
    // latched yet, so the APB fields take the live bus values instead.
    always_comb begin
        if (accept_s) begin
            ld_addr_s  = Haddr;
            ld_write_s = Hwrite;
            ld_sel_s   = sel_s;
        end else begin
            ld_addr_s  = addr_r;
            ld_write_s = write_r;
            ld_sel_s   = sel_r;
        end
    end

`ifdef AHB_APB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Watchdog: counts ACCESS cycles stalled on Pready, cleared in SETUP
    always_ff @(posedge Hclk or negedge Hrestn) begin
        if (!Hrestn) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == S_SETUP) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == S_ACCESS) && !Pready) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th stalled cycle.
    assign tmo_s = (state_r == S_ACCESS) & ~Pready &
                   (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_s = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = new_state_s;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WWAIT: state_nxt_s = S_SETUP;
            S_SETUP: state_nxt_s = S_ACCESS;
            S_ACCESS: begin
                if (Pready && Pslverr) begin
                    state_nxt_s = S_ERR1;
                end else if (Pready) begin
                    state_nxt_s = accept_s ? new_state_s : S_IDLE;
                end else if (tmo_s) begin
                    state_nxt_s = S_ERR1;
                end else begin
                    state_nxt_s = S_ACCESS;
                end
            end
            S_ERR1: state_nxt_s = S_ERR2;
            S_ERR2: begin
                if (accept_s) begin
                    state_nxt_s = new_state_s;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and address-phase capture
    always_ff @(posedge Hclk or negedge Hrestn) begin
        if (!Hrestn) begin
            state_r <= S_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            write_r <= 1'b0;
            sel_r   <= {NSLV{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r  <= Haddr;
                write_r <= Hwrite;
                sel_r   <= sel_s;
            end
        end
    end

    // APB outputs and AHB response, all registered from the next state
    always_ff @(posedge Hclk or negedge Hrestn) begin
        if (!Hrestn) begin
            psel_r    <= {NSLV{1'b0}};
            penable_r <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwrite_r  <= 1'b0;
            pwdata_r  <= {DATA_W{1'b0}};
            hresp_r   <= HRESP_OKAY;
        end else begin
            if (state_nxt_s == S_SETUP) begin
                psel_r   <= ld_sel_s;
                paddr_r  <= ld_addr_s;
                pwrite_r <= ld_write_s;
            end else if (state_nxt_s != S_ACCESS) begin
                psel_r   <= {NSLV{1'b0}};
            end
            penable_r <= (state_nxt_s == S_ACCESS);
            if (state_r == S_WWAIT) begin
                pwdata_r <= Hwdata;
            end
            if ((state_nxt_s == S_ERR1) || (state_nxt_s == S_ERR2)) begin
                hresp_r <= HRESP_ERROR;
            end else begin
                hresp_r <= HRESP_OKAY;
            end
        end
    end

    assign Hreadyout = hready_s;
    assign Hresp     = hresp_r;
    assign Hrdata    = Prdata;
    assign Pselx     = psel_r;
    assign Penable   = penable_r;
    assign Pwrite    = pwrite_r;
    assign Paddr     = paddr_r;
    assign Pwdata    = pwdata_r;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge_mc
// Self-checking bench for ahb_apb_bridge_mc (ADDR_W=32, DATA_W=32, NSLV=4).
// A small APB slave model answers with a configurable number of wait
// states and optional Pslverr; each AHB transfer is predicted as a list of
// per-cycle (Hreadyout, Hresp) pairs plus the single APB access expected.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_mc;

    localparam int unsigned NSLV = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] WIN  = 32'h0400_0000;

    logic        Hclk = 1'b0;
    logic        Hrestn = 1'b1;
    logic [31:0] Haddr = 32'h0;
    logic [1:0]  Htrans = 2'b00;
    logic        Hwrite = 1'b0;
    logic [2:0]  Hsize = 3'd2;
    logic [31:0] Hwdata = 32'h0;
    logic        Hreadyin = 1'b1;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    always #5 Hclk = ~Hclk;

    ahb_apb_bridge_mc #(
        .ADDR_W(32), .DATA_W(32), .NSLV(4), .SLV_BASE(32'h8000_0000),
        .SLV_WIN_LOG2(26), .TIMEOUT(16)
    ) dut (
        .Hclk(Hclk), .Hrestn(Hrestn), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // APB slave model: nwait_cfg stalled ACCESS cycles, then ready
    int unsigned nwait_cfg = 0;
    logic        slverr_cfg = 1'b0;
    logic [31:0] prdata_cfg = 32'h0;
    int unsigned wcnt = 0;

    always @(posedge Hclk) begin
        if (Penable && !Pready) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
    end
    assign Pready  = Penable && (wcnt >= nwait_cfg);
    assign Pslverr = Pready && slverr_cfg;
    assign Prdata  = prdata_cfg;

    // APB monitor: records completed accesses and any select activity
    int          nacc = 0;
    int          nsel = 0;
    logic [3:0]  m_sel = 4'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_write = 1'b0;

    always @(negedge Hclk) begin
        if (Pselx != 4'h0) nsel <= nsel + 1;
        if ((Pselx != 4'h0) && Penable && Pready) begin
            nacc    <= nacc + 1;
            m_sel   <= Pselx;
            m_addr  <= Paddr;
            m_write <= Pwrite;
            m_wdata <= Pwdata;
        end
    end

    // One isolated transfer starting from an idle bridge; returns idle.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int unsigned nw, input logic serr);
        logic       hit;
        logic       bad;
        logic [3:0] sel_exp;
        logic [2:0] exp_q[$];   // {Hreadyout, Hresp}
        int         acc0;
        int         sel0;
        hit     = (addr >= BASE) && (((addr - BASE) / WIN) < NSLV);
        sel_exp = hit ? 4'(32'd1 << ((addr - BASE) / WIN)) : 4'h0;
        bad     = !hit || (size > 3'd2);
        if (bad) begin
            exp_q.push_back(3'b001);
            exp_q.push_back(3'b101);
        end else begin
            for (int i = 0; i < (wr ? 2 : 1); i++) exp_q.push_back(3'b000);
            for (int i = 0; i < int'(nw); i++)     exp_q.push_back(3'b000);
            if (serr) begin
                exp_q.push_back(3'b000);
                exp_q.push_back(3'b001);
                exp_q.push_back(3'b101);
            end else begin
                exp_q.push_back(3'b100);
            end
        end
        nwait_cfg  = nw;
        slverr_cfg = serr;
        prdata_cfg = rdata;
        acc0 = nacc;
        sel0 = nsel;
        Haddr  = addr;
        Htrans = 2'b10;
        Hwrite = wr;
        Hsize  = size;
        chk_val("idle_rdy", Hreadyout, 1);
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        Hwdata = wdata;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Hclk);
            chk_val("hreadyout", Hreadyout, exp_q[i][2]);
            chk_val("hresp", Hresp, exp_q[i][1:0]);
            if (i == exp_q.size() - 1 && !bad && !serr && !wr)
                chk_val("hrdata", Hrdata, rdata);
            @(posedge Hclk); #1;
        end
        chk_val("apb_count", nacc - acc0, bad ? 0 : 1);
        if (bad) begin
            chk_val("no_psel", nsel - sel0, 0);
        end else begin
            chk_val("psel", m_sel, sel_exp);
            chk_val("paddr", m_addr, addr);
            chk_val("pwrite", m_write, wr);
            if (wr) chk_val("pwdata", m_wdata, wdata);
        end
    endtask

    initial begin
        // Reset state
        #1 Hrestn = 1'b0;
        #2;
        chk_val("rst_psel", Pselx, 0);
        chk_val("rst_penable", Penable, 0);
        chk_val("rst_pwrite", Pwrite, 0);
        chk_val("rst_paddr", Paddr, 0);
        chk_val("rst_pwdata", Pwdata, 0);
        chk_val("rst_hresp", Hresp, 0);
        chk_val("rst_hready", Hreadyout, 1);
        @(negedge Hclk); Hrestn = 1'b1;
        @(posedge Hclk); #1;

        // Directed cases
        run_xfer(32'h8400_0010, 1'b0, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_xfer(32'h8800_0004, 1'b1, 3'd2, 32'h1234_5678, 32'h0, 3, 1'b0);
        run_xfer(32'h8000_0008, 1'b0, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1'b1);
        run_xfer(32'h9000_0000, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0);
        run_xfer(32'h8C00_0000, 1'b1, 3'd3, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        run_xfer(32'h8FFF_FFFC, 1'b1, 3'd0, 32'h0BAD_CAFE, 32'h0, 1, 1'b1);

        // Back-to-back reads: slave 0 then slave 3
        nwait_cfg = 0; slverr_cfg = 1'b0; prdata_cfg = 32'hA5A5_0001;
        Haddr = 32'h8000_0020; Htrans = 2'b10; Hwrite = 1'b0; Hsize = 3'd2;
        @(posedge Hclk); #1;
        Haddr = 32'h8C00_0040;
        @(negedge Hclk);
        chk_val("b2b_setup0_sel", Pselx, 4'b0001);
        chk_val("b2b_setup0_rdy", Hreadyout, 0);
        @(posedge Hclk); #1;
        @(negedge Hclk);
        chk_val("b2b_acc0_rdy", Hreadyout, 1);
        chk_val("b2b_acc0_data", Hrdata, 32'hA5A5_0001);
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        @(negedge Hclk);
        chk_val("b2b_setup3_sel", Pselx, 4'b1000);
        chk_val("b2b_setup3_pen", Penable, 0);
        chk_val("b2b_setup3_addr", Paddr, 32'h8C00_0040);
        @(posedge Hclk); #1;
        @(negedge Hclk);
        chk_val("b2b_acc3_rdy", Hreadyout, 1);
        chk_val("b2b_acc3_resp", Hresp, 0);
        @(posedge Hclk); #1;

        // Reset asserted in the middle of a stalled ACCESS
        nwait_cfg = 8;
        Haddr = 32'h8400_0000; Htrans = 2'b10; Hwrite = 1'b0;
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        @(posedge Hclk); #1;
        @(negedge Hclk);
        chk_val("mid_acc_pen", Penable, 1);
        chk_val("mid_acc_sel", Pselx, 4'b0010);
        #2 Hrestn = 1'b0;
        #1;
        chk_val("mid_rst_sel", Pselx, 0);
        chk_val("mid_rst_pen", Penable, 0);
        chk_val("mid_rst_paddr", Paddr, 0);
        chk_val("mid_rst_rdy", Hreadyout, 1);
        @(negedge Hclk); Hrestn = 1'b1;
        @(posedge Hclk); #1;
        nwait_cfg = 0;

`ifdef AHB_APB_TIMEOUT_EN
        // Watchdog: SETUP plus 16 stalled ACCESS cycles, then ERR1/ERR2
        nwait_cfg = 1000;
        Haddr = 32'h8400_0100; Htrans = 2'b10; Hwrite = 1'b0; Hsize = 3'd2;
        @(posedge Hclk); #1;
        Htrans = 2'b00;
        for (int i = 0; i < 17; i++) begin
            @(negedge Hclk);
            chk_val("tmo_wait_rdy", Hreadyout, 0);
            @(posedge Hclk); #1;
        end
        @(negedge Hclk);
        chk_val("tmo_err1_resp", Hresp, 1);
        chk_val("tmo_err1_rdy", Hreadyout, 0);
        chk_val("tmo_err1_sel", Pselx, 0);
        @(posedge Hclk); #1;
        @(negedge Hclk);
        chk_val("tmo_err2_resp", Hresp, 1);
        chk_val("tmo_err2_rdy", Hreadyout, 1);
        @(posedge Hclk); #1;
        nwait_cfg = 0;
`endif

        // Randomized transfers
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k < 7)
                a = BASE + 32'($urandom_range(0, 3)) * WIN + (32'($urandom) & 32'h03FF_FFFC);
            else if (k < 9)
                a = 32'h9000_0000 + (32'($urandom) & 32'h0FFF_FFFC);
            else
                a = 32'h7FFF_FFF0;
            if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(3, 7));
            else                           sz = 3'($urandom_range(0, 2));
            run_xfer(a, 1'($urandom_range(0, 1)), sz, 32'($urandom), 32'($urandom),
                     $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_mc.md
# ahb_apb_bridge_mc

Parametrised AHB-Lite slave to APB3 master bridge and the successor to the fixed four-slave bridge.

- Adds N-way address decode, APB3 wait states (Pready), error mapping (Pslverr to two-cycle AHB ERROR), unmapped-address and illegal-size errors, and back-to-back transfers.
- Sits between the AHB interconnect and the APB peripheral cluster, clocked by Hclk.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width (32 or 64).
- NSLV, 4: APB slave count (1..16).
- SLV_BASE, 32'h8000_0000: base of slave 0 window.
- SLV_WIN_LOG2, 26: log2 of window size; slave i occupies SLV_BASE + i·2^SLV_WIN_LOG2.
- TIMEOUT, 16: Pready watchdog limit in cycles. Used only with the macro under Configuration.

Ports (one clock; reset is asynchronous and active-low):
- Hclk  in  1  clock
- Hrestn  in  1  asynchronous active-low reset
- Haddr  in  ADDR_W  AHB address
- Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Hwrite  in  1  1 = write
- Hsize  in  3  transfer size
- Hwdata  in  DATA_W  write data, valid in data phase
- Hreadyin  in  1  bus-level HREADY
- Hreadyout  out  1  bridge ready
- Hresp  out  2  OKAY=00, ERROR=01
- Hrdata  out  DATA_W  read data, equals Prdata
- Pselx  out  NSLV  one-hot slave select
- Penable  out  1  APB access phase
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  muxed slave read data
- Pready  in  1  slave ready (APB3)
- Pslverr  in  1  slave error (APB3)

## Operation
- Accept condition:
  - Hreadyout & Hreadyin & Htrans[1].
  - On accept, latch Haddr, Hwrite and Hsize, and decode the slave index.
  - BUSY or IDLE transfers are ignored and receive OKAY.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - Accepted write goes to WWAIT.
  - Accepted read goes to SETUP.
  - Unmapped address, or Hsize > log2(DATA_W/8), goes to ERR1 with no APB activity.
- WWAIT: latch Hwdata into Pwdata, then go to SETUP.
- SETUP: Pselx[idx]=1, Penable=0, Paddr and Pwrite driven; go to ACCESS.
- ACCESS:
  - Penable=1.
  - Pready=0: stay in ACCESS.
  - Pready=1 & ~Pslverr: complete. A simultaneous new accept goes to WWAIT, SETUP or ERR1; otherwise go to IDLE.
  - Pready=1 & Pslverr: go to ERR1.
- ERR1: Hresp=ERROR, Hreadyout=0, Pselx=0. Go to ERR2.
- ERR2:
  - Hresp=ERROR, Hreadyout=1.
  - The accept condition is evaluated here; otherwise go to IDLE.
  - A master cancelling to IDLE is handled naturally.
- Hreadyout is combinational: 1 in IDLE, in ERR2, and in ACCESS when Pready & ~Pslverr. 0 otherwise.
- Hresp is registered from state; OKAY outside ERR1/ERR2.
- Pselx, Penable, Paddr, Pwrite and Pwdata are registered.
- Paddr holds the full Haddr; Pwdata holds its value until the next write.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hresp=OKAY, Hreadyout=1.
- Reset mid-transfer drops Pselx and Penable immediately.
- Read, zero-wait: address T0; SETUP T1; ACCESS T2 with Hreadyout=1 and Hrdata valid. Data-phase latency is 2 cycles.
- Write, zero-wait: address T0; WWAIT T1; SETUP T2; ACCESS T3 with Hreadyout=1. Latency is 3 cycles.
- Each cycle of Pready=0 adds one cycle.
- Error: two cycles (ERR1, ERR2) after ACCESS or after the address phase.
- Back-to-back transfers: no idle cycle between ACCESS completion and the next SETUP or WWAIT.

## Configuration
- AHB_APB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT+1) counts ACCESS cycles with Pready=0.
  - On reaching TIMEOUT, drop Pselx/Penable and go to ERR1.
  - The counter clears on SETUP.
- Undefined: no counter; ACCESS waits indefinitely for Pready.

## Structure
- Package ahb_apb_pkg:
  - htrans_t, hresp_t, bridge_state_t enums.
  - HRESP_OKAY/HRESP_ERROR constants.
  - function slv_decode(addr, base, win_log2, nslv), returning a hit flag and an index.
- Sub-module ahb_apb_decode: combinational Haddr to one-hot select plus hit flag, parametrised by NSLV/SLV_BASE/SLV_WIN_LOG2.

## Test plan
- Read from 0x8400_0010 with Pready=1 and Prdata=0xDEAD_BEEF -> Pselx=0010, Hrdata=0xDEAD_BEEF with Hreadyout=1 at T2, Hresp=OKAY.
- Write of 0x1234_5678 to 0x8800_0004 with Pready held low 3 cycles -> Pwdata=0x1234_5678, Pselx=0100, Hreadyout low for 5 data-phase cycles, then OKAY.
- Read with Pready=1 and Pslverr=1 -> Hresp=01 with Hreadyout=0, then Hresp=01 with Hreadyout=1, then IDLE.
- Access to 0x9000_0000 (unmapped, NSLV=4) -> no Pselx asserted; two-cycle ERROR.
- Back-to-back NONSEQ reads to slaves 0 and 3 -> SETUP for slave 3 in the cycle after slave-0 ACCESS completes. Also deassert Hrestn mid-ACCESS -> all APB outputs 0 immediately.
- With AHB_APB_TIMEOUT_EN and TIMEOUT=16, hold Pready=0 -> ERR1 after 16 ACCESS cycles, Pselx=0.
